// File: rtl/uart_pkg.sv
// Shared UART constants: default baud generator geometry and standard divisors
// for a 50 MHz clock with 16x oversampling (FRAC_W = 4).
package uart_pkg;

    localparam int DEF_DIV_W  = 16;
    localparam int DEF_FRAC_W = 4;
    localparam int DEF_OVS    = 16;

    // 50e6 / (115200*16) = 27.127 -> 27 + 2/16
    localparam int BAUD_115200_INT  = 27;
    localparam int BAUD_115200_FRAC = 2;
    // 50e6 / (9600*16) = 325.52 -> 325 + 8/16
    localparam int BAUD_9600_INT    = 325;
    localparam int BAUD_9600_FRAC   = 8;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Integer+fractional clock divider producing the oversample tick; the fractional
// accumulator stretches one period by a cycle each time it carries.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [DIV_W-1:0]  shadow_int,
    input  logic [FRAC_W-1:0] shadow_frac,
    output logic              tick_cond,
    output logic              s_tick
);

    logic [DIV_W:0]  cnt_q, cnt_d;
    logic [DIV_W:0]  period;
    logic [DIV_W:0]  period_m1;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0] acc_sum;
    logic            ext_q, ext_d;
    logic            s_tick_q, s_tick_d;
    logic            terminal;

    always_comb begin
        // One extra counter bit keeps the longest period (max int plus carry) representable.
        period    = {1'b0, shadow_int} + {{DIV_W{1'b0}}, ext_q};
        period_m1 = period - {{DIV_W{1'b0}}, 1'b1};
        acc_sum   = {1'b0, acc_q} + {1'b0, shadow_frac};
        terminal  = (cnt_q == period_m1);
        tick_cond = enable && !restart && terminal;

        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ext_d    = ext_q;
        s_tick_d = 1'b0;

        if (!enable || restart) begin
            cnt_d = '0;
            acc_d = '0;
            ext_d = 1'b0;
        end else if (terminal) begin
            cnt_d    = '0;
            s_tick_d = 1'b1;
            acc_d    = acc_sum[FRAC_W-1:0];
            ext_d    = acc_sum[FRAC_W];
        end else begin
            cnt_d = cnt_q + {{DIV_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            ext_q    <= 1'b0;
            s_tick_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ext_q    <= ext_d;
            s_tick_q <= s_tick_d;
        end
    end

    assign s_tick = s_tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Baud tick generator: shadowed divisor, oversample tick, bit-rate tick and
// mid-bit sample tick, all registered and aligned to the same edge.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OVS    = DEF_OVS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              s_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              div_err
);

    localparam int OS_W = $clog2(OVS);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVS / 2 - 1);

    logic [DIV_W-1:0]  shadow_int_q, shadow_int_d;
    logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic              div_err_q, div_err_d;
    logic              bit_tick_q, bit_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              load;
    logic              tick_cond;

    always_comb begin
        load          = !enable || restart;
        shadow_int_d  = shadow_int_q;
        shadow_frac_d = shadow_frac_q;
        div_err_d     = div_err_q;
        os_cnt_d      = os_cnt_q;
        bit_tick_d    = 1'b0;
        mid_tick_d    = 1'b0;

        if (load) begin
            // A zero divisor would never reach terminal count; run at divide-by-1 and flag it.
            shadow_int_d  = (div_int == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : div_int;
            shadow_frac_d = div_frac;
            div_err_d     = (div_int == '0);
            os_cnt_d      = '0;
        end else if (tick_cond) begin
            os_cnt_d   = os_cnt_q + OS_W'(1);
            bit_tick_d = (os_cnt_q == OS_LAST);
            mid_tick_d = (os_cnt_q == OS_MID);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_int_q  <= {{(DIV_W-1){1'b0}}, 1'b1};
            shadow_frac_q <= '0;
            div_err_q     <= 1'b0;
            os_cnt_q      <= '0;
            bit_tick_q    <= 1'b0;
            mid_tick_q    <= 1'b0;
        end else begin
            shadow_int_q  <= shadow_int_d;
            shadow_frac_q <= shadow_frac_d;
            div_err_q     <= div_err_d;
            os_cnt_q      <= os_cnt_d;
            bit_tick_q    <= bit_tick_d;
            mid_tick_q    <= mid_tick_d;
        end
    end

    uart_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .restart     (restart),
        .shadow_int  (shadow_int_q),
        .shadow_frac (shadow_frac_q),
        .tick_cond   (tick_cond),
        .s_tick      (s_tick)
    );

    assign bit_tick = bit_tick_q;
    assign mid_tick = mid_tick_q;
    assign div_err  = div_err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: fixed divisors, restart alignment, shadowing,
// fractional spacing, zero divisor and asynchronous reset.
module tb_uart_baud_gen;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        restart;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        s_tick;
    logic        bit_tick;
    logic        mid_tick;
    logic        div_err;

    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;
    int   t0 = 0;
    logic exp_err = 1'b0;

    logic [31:0] exp_q[$];
    int          ticks[32];
    int          nt;
    int          bit_at;
    int          mid_at;

    uart_baud_gen dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .restart  (restart),
        .div_int  (div_int),
        .div_frac (div_frac),
        .s_tick   (s_tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .div_err  (div_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
        end
    endtask

    // Checks {s,bit,mid,err} for a fixed period p counted from the clearing edge t0.
    task automatic run_fixed(input int p, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            int   e;
            logic s, b, m;
            e = edge_n - t0;
            s = (e > 0) && (e % p == 0);
            b = (e > 0) && (e % (16 * p) == 0);
            m = (e > 0) && (e % (16 * p) == 8 * p);
            check_eq(tag, {28'd0, s_tick, bit_tick, mid_tick, div_err},
                          {28'd0, s, b, m, exp_err});
            @(negedge clk);
        end
    endtask

    task automatic align(input int p, input int phase);
        for (int k = 0; k < p && ((edge_n - t0) % p) != phase; k++)
            run_fixed(p, 1, "align");
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        t0 = edge_n;
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        restart  = 1'b0;
        div_int  = 16'd4;
        div_frac = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {28'd0, s_tick, bit_tick, mid_tick, div_err}, 32'd0);

        // divide by 4: tick every 4, mid at 32, bit at 64
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        t0 = edge_n;
        run_fixed(4, 140, "div4");

        // restart with cnt=2, then bit_tick 64 cycles after restart
        align(4, 2);
        pulse_restart();
        run_fixed(4, 70, "rs_mid");

        // divisor change is shadowed while running
        div_int = 16'd6;
        run_fixed(4, 30, "chg_ignored");

        // restart on a terminal-count edge suppresses the tick, then period 6
        align(4, 3);
        pulse_restart();
        run_fixed(6, 120, "div6");

        // enable falling on a terminal edge emits no tick
        align(6, 5);
        enable = 1'b0;
        @(negedge clk);
        check_eq("en_fall", {31'd0, s_tick}, 32'd0);

        // fractional 3 + 8/16
        div_int  = 16'd3;
        div_frac = 4'd8;
        @(negedge clk);
        enable = 1'b1;
        t0 = edge_n;
        exp_q = {32'd3, 32'd6, 32'd10, 32'd13, 32'd17, 32'd20, 32'd24, 32'd27};
        nt = 0;
        bit_at = -1;
        mid_at = -1;
        for (int i = 0; i < 64; i++) begin
            int e;
            e = edge_n - t0;
            if (s_tick) begin
                if (nt < 32) ticks[nt] = e;
                nt++;
                if (exp_q.size() > 0) check_eq("frac_pos", e, exp_q.pop_front());
            end
            if (bit_tick && bit_at < 0) bit_at = e;
            if (mid_tick && mid_at < 0) mid_at = e;
            @(negedge clk);
        end
        check_eq("frac_left", exp_q.size(), 32'd0);
        check_eq("frac_count", nt, 32'd18);
        check_eq("frac_span", (nt >= 17) ? ticks[16] - ticks[0] : -1, 32'd56);
        check_eq("frac_bit", bit_at, 32'd55);
        check_eq("frac_mid", mid_at, 32'd27);

        // zero divisor: flagged, runs at divide-by-1
        div_int  = 16'd0;
        div_frac = 4'd0;
        enable   = 1'b0;
        @(negedge clk);
        exp_err = 1'b1;
        check_eq("err_idle", {28'd0, s_tick, bit_tick, mid_tick, div_err}, 32'd1);
        enable = 1'b1;
        t0 = edge_n;
        run_fixed(1, 40, "div1");
        check_eq("pre_rst", {28'd0, s_tick, bit_tick, mid_tick, div_err}, 32'hb);

        // asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst", {28'd0, s_tick, bit_tick, mid_tick, div_err}, 32'd0);
        div_int = 16'd5;
        enable  = 1'b0;
        @(negedge clk);
        check_eq("rst_hold", {28'd0, s_tick, bit_tick, mid_tick, div_err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        exp_err = 1'b0;
        enable  = 1'b1;
        t0 = edge_n;
        run_fixed(5, 60, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
